simon_playback_seq: RTL and testbench
=====================================

# simon_playback_seq

Sequences the Simon sequence memory during the "show" phase of a round: it walks read addresses `0..length-1`, holds each stored colour on the LEDs for a fixed number of game ticks, then blanks the LEDs for a fixed gap. It sits between the round-control FSM and the sequence memory's read port, and drives the LED bus while busy. The FSM issues `start` with the current round length and waits for `done`.

## Interface
- `DEPTH`, default 10: sequence memory depth; the maximum legal `length`.
- `ADDR_W`, default 4: read address width; must satisfy `2**ADDR_W >= DEPTH`.
- `ON_TICKS`, default 3: number of ticks each colour is shown; must be ≥1.
- `OFF_TICKS`, default 1: number of ticks of dark gap after each colour; must be ≥1.
- `CNT_W`, default 4: tick counter width; must hold `max(ON_TICKS, OFF_TICKS)`.

Ports:
- `clk`, in, 1: the single clock. Every register in the block is clocked by it.
- `reset`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-`clk` timing strobe from the clock divider. It gates only the ON/GAP counting.
- `start`, in, 1: request to begin playback. Sampled only in IDLE.
- `length`, in, `ADDR_W+1`: number of entries to play. Latched when `start` is accepted.
- `abort`, in, 1: synchronous cancel. Highest priority.
- `rd_addr`, out, `ADDR_W`: registered read address to the sequence memory.
- `rd_data`, in, 2: colour read back from memory. Valid one `clk` after `rd_addr` changes (synchronous read).
- `led`, out, 4: one-hot display. `led[rd colour]` is high in SHOW; all LEDs are 0 otherwise.
- `busy`, out, 1: high in FETCH, LOAD, SHOW and GAP.
- `done`, out, 1: one-`clk` pulse when playback completes.
- `len_err`, out, 1: one-`clk` pulse when `start` arrives with an illegal `length`.

## Operation
- States: IDLE, FETCH, LOAD, SHOW, GAP, DONE. All outputs are registered or decoded from state.
- **IDLE**
  - `start=1` and `1 <= length <= DEPTH`: latch `length`, clear the index, set `rd_addr=0`, go to FETCH.
  - `start=1` with `length=0` or `length>DEPTH`: pulse `len_err` next cycle and stay in IDLE.
- **FETCH**: wait one `clk` for the memory read, then go to LOAD.
- **LOAD**: capture `rd_data` into the colour register, clear the tick counter, go to SHOW.
- **SHOW**
  - `led = 4'b0001 << colour`.
  - Count `tick` strobes seen while in SHOW.
  - On the `ON_TICKS`-th tick, clear the counter and go to GAP.
- **GAP**
  - `led = 0`.
  - On the `OFF_TICKS`-th tick:
    - If `index == length-1`, go to DONE.
    - Otherwise increment the index, set `rd_addr = index+1`, go to FETCH.
- **DONE**: `done=1`, `busy=0`, `rd_addr` holds its value. Go to IDLE next cycle.
- **Abort**: `abort=1` in any state forces IDLE on the next edge. `led=0`, `busy=0`, no `done` pulse. `abort` beats `start` in the same cycle.
- `start` while busy or in DONE is ignored and not queued.
- Inputs `length` and `rd_data` are ignored outside the states that sample them. A change to `length` mid-playback has no effect.
- `tick` is ignored in IDLE, FETCH, LOAD and DONE. A `tick` arriving in the same cycle as a SHOW→GAP or GAP→FETCH transition is consumed by the state being left.
- Index arithmetic is `ADDR_W` bits. It never wraps, because `length <= DEPTH <= 2**ADDR_W`.

## Timing
- Reset (`reset=0`, asynchronous) gives state IDLE, `rd_addr=0`, `led=0`, `busy=0`, `done=0`, `len_err=0`, index 0, counter 0. Reset asserted mid-playback has the same effect immediately.
- `start` accepted at edge N:
  - FETCH during cycle N+1, with `rd_addr` valid.
  - LOAD during cycle N+2.
  - LED first valid in cycle N+3.
- Per entry, the gap between the LED going dark and the next colour showing is exactly 2 `clk` (FETCH, LOAD) after the last GAP tick.
- `done` rises the cycle after the final GAP tick edge and lasts exactly one cycle. `busy` falls in that same cycle.
- `len_err` asserts the cycle after the offending `start` and lasts exactly one cycle.

## Test plan
- **Basic playback** (`ON_TICKS=3`, `OFF_TICKS=1`, tick every 4 clk). Memory holds {2,0,3}. `start`, `length=3` → `led` shows `0100`, `0000`, `0001`, `0000`, `1000`, `0000`, each ON phase exactly 3 ticks. `rd_addr` goes 0, 1, 2. One `done` pulse; `busy` high from cycle N+1 until `done`.
- **Length boundaries**: `length=1` plays one colour, then `done`. `length=10` plays all 10 entries with `rd_addr` 0..9. `length=0` and `length=11` each give one `len_err` pulse, `busy` stays 0, and there is no `done`.
- **Abort mid-SHOW on entry 1** → next cycle `led=0`, `busy=0`, IDLE, no `done`. A subsequent `start` with `length=2` plays from `rd_addr=0`.
- **`start` asserted continuously during playback and changing `length`** → no restart; playback uses the latched length. `start`+`abort` together in IDLE → stays in IDLE.
- **Reset mid-GAP** (`reset` low asynchronously between edges) → all outputs 0 immediately. After release, `start` plays normally.
- **Tick aligned with the LOAD→SHOW edge** → the ON phase still counts exactly `ON_TICKS` ticks seen while in SHOW. `tick` held low stalls SHOW indefinitely with the LED held.

Source files
------------

// File: rtl/simon_playback_seq.sv
// Simon "show" phase sequencer: walks memory addresses 0..length-1, lights each
// stored colour for ON_TICKS ticks, then blanks the LEDs for OFF_TICKS ticks.
module simon_playback_seq #(
  parameter int DEPTH     = 10,
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 1,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHOW, GAP, DONE} state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len_q;
  logic [1:0]        colour;
  logic [CNT_W-1:0]  cnt;

  logic len_ok, last_ent, on_end, off_end;

  assign len_ok   = (length != '0) && (length <= DEPTH_L);
  assign last_ent = ({1'b0, idx} == (len_q - 1'b1));
  assign on_end   = (state == SHOW) && tick && (cnt == ON_LAST);
  assign off_end  = (state == GAP)  && tick && (cnt == OFF_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && len_ok) state_d = FETCH;
        FETCH:   state_d = LOAD;
        LOAD:    state_d = SHOW;
        SHOW:    if (on_end) state_d = GAP;
        GAP:     if (off_end) state_d = last_ent ? DONE : FETCH;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      len_q   <= '0;
      rd_addr <= '0;
      colour  <= '0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= (state == IDLE) && start && !len_ok && !abort;
      if (!abort) begin
        case (state)
          IDLE: if (start && len_ok) begin
            len_q   <= length;
            idx     <= '0;
            rd_addr <= '0;
          end
          LOAD: begin
            colour <= rd_data;
            cnt    <= '0;
          end
          SHOW: if (tick) cnt <= on_end ? '0 : cnt + 1'b1;
          GAP: if (tick) begin
            cnt <= off_end ? '0 : cnt + 1'b1;
            // Last entry leaves rd_addr pointing at it through DONE.
            if (off_end && !last_ent) begin
              idx     <= idx + 1'b1;
              rd_addr <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == FETCH) || (state == LOAD) || (state == SHOW) || (state == GAP);
  assign done = (state == DONE);
  assign led  = (state == SHOW) ? (4'b0001 << colour) : 4'b0000;

endmodule

// File: tb/tb_simon_playback_seq.sv
// Directed bench for simon_playback_seq: memory model, tick generator and a
// scoreboard queue of expected {address, colour} per displayed entry.
module tb_simon_playback_seq;

  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 1;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [4:0] length;
  logic [3:0] rd_addr;
  logic [1:0] rd_data = 2'd0;
  logic [3:0] led;
  logic       busy, done, len_err;

  logic       tick, tick_auto, tick_man;
  logic [1:0] tdiv = 2'd0;

  logic [1:0] mem [16];

  typedef struct {
    logic [3:0] addr;
    logic [1:0] col;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_tot  = 0;

  simon_playback_seq #(
    .DEPTH(10), .ADDR_W(4), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .length(length),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .led(led),
    .busy(busy), .done(done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Tick every 4 clk when free-running; otherwise driven directly by the sequence.
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign tick = tick_auto ? (tdiv == 2'd3) : tick_man;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.addr = 4'(i);
      e.col  = mem[i];
      sb.push_back(e);
    end
  endtask

  // Returns at the negedge of the FETCH cycle when the start is accepted.
  task automatic do_start(input logic [4:0] len);
    @(negedge clk); start = 1'b1; length = len;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_led(input bit on);
    int g = 0;
    while (((led != 4'd0) != on) && g < 300) begin
      @(negedge clk); g++;
    end
    chk(on ? "wait_led_on" : "wait_led_off", 32'((led != 4'd0) == on), 32'd1);
  endtask

  task automatic play_check(input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      int   n = 0;
      int   g = 0;
      wait_led(1'b1);
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
        return;
      end
      e = sb.pop_front();
      chk("led_colour", 32'(led), 32'(4'b0001 << e.col));
      chk("rd_addr", 32'(rd_addr), 32'(e.addr));
      do begin
        if (tick) n++;
        @(negedge clk); g++;
      end while (led != 4'd0 && g < 500);
      chk("on_ticks", n, ON_TICKS);
    end
    begin
      int g = 0;
      while (!done && g < 50) begin
        @(negedge clk); g++;
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic bad_len(input logic [4:0] len);
    do_start(len);
    chk("len_err_pulse", 32'(len_err), 32'd1);
    chk("len_err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len_err_one_cycle", 32'(len_err), 32'd0);
    chk("len_err_no_done", 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pat [10] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? pat[i] : 2'd0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; length = 5'd0;
    tick_auto = 1'b1; tick_man = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic playback with start-to-LED latency
    push_exp(3);
    do_start(5'd3);
    chk("n1_busy", 32'(busy), 32'd1);
    chk("n1_rd_addr", 32'(rd_addr), 32'd0);
    chk("n1_led", 32'(led), 32'd0);
    @(negedge clk);
    chk("n2_led", 32'(led), 32'd0);
    chk("n2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("n3_led", 32'(led), 32'b0100);
    play_check(3);

    // Length boundaries
    push_exp(1);  do_start(5'd1);  play_check(1);
    push_exp(10); do_start(5'd10); play_check(10);
    bad_len(5'd0);
    bad_len(5'd11);

    // Abort while entry 1 is shown
    do_start(5'd3);
    wait_led(1'b1); wait_led(1'b0); wait_led(1'b1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_led", 32'(led), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    begin
      bit seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done || busy) seen = 1'b1;
      end
      chk("abort_quiet", 32'(seen), 32'd0);
    end
    push_exp(2); do_start(5'd2); play_check(2);

    // start held through playback with length wandering
    push_exp(3);
    @(negedge clk); start = 1'b1; length = 5'd3;
    fork
      play_check(3);
      begin
        for (int k = 0; k < 3000; k++) begin
          @(negedge clk);
          if (done) break;
          length = 5'($urandom_range(0, 12));
        end
        start = 1'b0;
      end
    join
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_no_restart", 32'(busy), 32'd0);

    // abort beats start in IDLE
    @(negedge clk); start = 1'b1; length = 5'd2; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    chk("abort_start_idle", 32'(busy), 32'd0);

    // Asynchronous reset during entry 1 gap
    do_start(5'd3);
    wait_led(1'b1); wait_led(1'b0); wait_led(1'b1); wait_led(1'b0);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_rd_addr", 32'(rd_addr), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b1;
    push_exp(3); do_start(5'd3); play_check(3);

    // Manual ticks: tick on LOAD->SHOW edge is ignored; tick low stalls SHOW
    tick_auto = 1'b0; tick_man = 1'b0;
    repeat (2) @(negedge clk);
    do_start(5'd1);
    @(negedge clk); tick_man = 1'b1;
    @(negedge clk); tick_man = 1'b0;
    chk("man_show_led", 32'(led), 32'(4'b0001 << mem[0]));
    repeat (20) @(negedge clk);
    chk("stall_led", 32'(led), 32'(4'b0001 << mem[0]));
    chk("stall_busy", 32'(busy), 32'd1);
    for (int k = 0; k < ON_TICKS; k++) begin
      tick_man = 1'b1;
      @(negedge clk); tick_man = 1'b0;
      chk("man_on_count", 32'(led), (k < ON_TICKS - 1) ? 32'(4'b0001 << mem[0]) : 32'd0);
      @(negedge clk);
    end
    tick_man = 1'b1;
    @(negedge clk); tick_man = 1'b0;
    chk("man_done", 32'(done), 32'd1);
    chk("man_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("man_done_cleared", 32'(done), 32'd0);
    tick_auto = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
